regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Parametrised multi-read-port register file for the pipelined datapath's decode stage, replacing the fixed 32×8, two-port register bank. It has registered reads with write-first bypass and a per-register busy scoreboard that flags reads of registers with a pending writeback. Per-port read-freeze lets the hazard unit stall decode without losing operands.

## Interface
- DATA_W, 8, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, never busy
- RESET_INIT, 1, 1: reset loads reg[i] = i mod 2**DATA_W; 0: reset loads all zero
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears/initialises all state
- rd_en  in  NUM_RD  per-port read enable; low = hold rd_data/rd_busy
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  registered read data
- rd_busy  out  NUM_RD  registered: read register had a pending writeback
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- resv_en  in  1  reserve (mark busy) a destination at issue
- resv_addr  in  ADDR_W  destination being reserved
- any_busy  out  1  combinational OR of all busy bits (debug/drain)

## Operation
- Storage: 2**ADDR_W × DATA_W flops; busy vector of 2**ADDR_W bits.
- Write: on edge with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. With ZERO_REG=1, wr_addr=0 is dropped.
- Reserve: on edge with resv_en=1, busy[resv_addr] <= 1. With ZERO_REG=1, resv_addr=0 is ignored.
- Reserve and write to the same address in the same cycle: reserve wins, so busy stays 1 (new producer) while the data is still written.
- Read port p, on edge with rd_en[p]=1:
  - rd_data[p] <= (wr_en && wr_addr==rd_addr[p] && !(ZERO_REG && addr==0)) ? wr_data : reg[rd_addr[p]] (write-first bypass).
  - With ZERO_REG=1, address 0 yields rd_data=0 and rd_busy=0.
- rd_busy[p] <= busy[rd_addr[p]] after this edge's write clear, before this edge's reserve. The reader is older than a same-cycle reservation; a same-cycle write satisfies it.
- rd_en[p]=0: rd_data[p] and rd_busy[p] hold.
- All ports are independent. Any number of ports may read the same address.
- Reset (any time, including mid-operation):
  - reg[] takes its RESET_INIT pattern.
  - busy all 0.
  - rd_data all 0; rd_busy all 0; any_busy 0.

## Timing
- Read latency is 1 cycle: address at edge N gives data visible after edge N.
- The write is visible to a non-bypassed read one edge later; a same-edge read gets it through the bypass.
- A reserve at edge N makes rd_busy=1 for reads sampled at edge N+1 onward.
- A write at edge M makes rd_busy=0 for reads sampled at edge M onward.
- any_busy is combinational from state, updating after each edge.
- No handshake on the write port: every asserted wr_en is accepted.

## Structure
- Package regfile_pkg:
  - default DATA_W/ADDR_W constants;
  - function init_val(index) for the RESET_INIT pattern;
  - localparam DEPTH.
- Sub-module rf_scoreboard holds the busy vector, reserve/clear priority and per-port busy lookup.
- The top level holds storage, bypass and the read registers.

## Test plan
- Reset, then read r5 and r31 on ports 0/1 -> rd_data = 0x05/0x1F (RESET_INIT=1), rd_busy = 0/0.
- Write r7 = 0xA5 while port 0 reads r7 on the same edge -> next cycle rd_data[0] = 0xA5 (bypass). Port 1 reading r8 -> 0x08.
- Write r0 = 0xFF; reserve r0; read r0 -> rd_data = 0, rd_busy = 0, any_busy = 0.
- Reserve r3 at edge N:
  - read r3 at N+1 -> rd_busy = 1;
  - write r3 = 0x3C at N+2 with same-edge read -> rd_data = 0x3C, rd_busy = 0.
- Same-edge write and reserve of r9 -> busy[9] = 1, a later read returns the new data with rd_busy = 1. Same-edge rd_en low on port 1 -> port 1 outputs unchanged.
- Assert reset mid-stream after writes and reservations -> all rd_data 0, busy cleared, r12 reads 0x0C afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the decode-stage register file.
// Default geometry plus the reset initialisation pattern.
package regfile_pkg;

   localparam int unsigned DATA_W_DEF = 8;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned DEPTH = 2 ** ADDR_W_DEF;

   // Reset pattern: register i holds i modulo 2**dw
   function automatic logic [31:0] init_val(
      input int unsigned idx,
      input int unsigned dw
   );
      if (dw >= 32) return idx;
      return idx & ((32'd1 << dw) - 32'd1);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one pending-writeback bit per register.
// Reserve beats a same-cycle write; readers see write clears, not reserves.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic                     resv_en,
   input  logic [ADDR_W-1:0]        resv_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        lookup,
   output logic                     any_busy
);

   localparam int unsigned NREG = 2 ** ADDR_W;
   localparam logic ZR = (ZERO_REG != 0);

   logic [NREG-1:0] busy;
   logic            wr_ok;
   logic            resv_ok;

   assign wr_ok   = wr_en && !(ZR && (wr_addr == '0));
   assign resv_ok = resv_en && !(ZR && (resv_addr == '0));
   assign any_busy = |busy;

   // Clear on writeback, then set on reserve so a new producer wins
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= '0;
      end else begin
         if (wr_ok) busy[wr_addr] <= 1'b0;
         if (resv_ok) busy[resv_addr] <= 1'b1;
      end
   end

   // Per-port lookup: this edge's write clears, this edge's reserve does not
   always_comb begin
      lookup = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         if (ZR && (rd_addr[p*ADDR_W +: ADDR_W] == '0)) begin
            lookup[p] = 1'b0;
         end else if (wr_en && (wr_addr == rd_addr[p*ADDR_W +: ADDR_W])) begin
            lookup[p] = 1'b0;
         end else begin
            lookup[p] = busy[rd_addr[p*ADDR_W +: ADDR_W]];
         end
      end
   end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with registered write-first reads.
// Read ports hold their outputs while disabled so decode can stall.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned NUM_RD = 2,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned RESET_INIT = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     resv_en,
   input  logic [ADDR_W-1:0]        resv_addr,
   output logic                     any_busy
);

   localparam int unsigned NREG = 2 ** ADDR_W;
   localparam logic ZR = (ZERO_REG != 0);

   logic [DATA_W-1:0] regs [NREG];
   logic [NUM_RD-1:0] lookup;
   logic              wr_ok;

   assign wr_ok = wr_en && !(ZR && (wr_addr == '0));

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .NUM_RD   (NUM_RD),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk       (clk),
      .reset     (reset),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .resv_en   (resv_en),
      .resv_addr (resv_addr),
      .rd_addr   (rd_addr),
      .lookup    (lookup),
      .any_busy  (any_busy)
   );

   // Storage: reset pattern, then accept every valid write
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREG; i++) begin
            regs[i] <= (RESET_INIT != 0) ?
                       DATA_W'(init_val(i, DATA_W)) : '0;
         end
      end else if (wr_ok) begin
         regs[wr_addr] <= wr_data;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              zero;
      logic              hit;
      logic [DATA_W-1:0] d_q;
      logic              b_q;

      assign a    = rd_addr[p*ADDR_W +: ADDR_W];
      assign zero = ZR && (a == '0);
      assign hit  = wr_en && (wr_addr == a);

      // Read register: zero reg, else bypass a same-edge write, else storage
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            d_q <= '0;
            b_q <= 1'b0;
         end else if (rd_en[p]) begin
            if (zero) d_q <= '0;
            else if (hit) d_q <= wr_data;
            else d_q <= regs[a];
            b_q <= lookup[p];
         end
      end

      assign rd_data[p*DATA_W +: DATA_W] = d_q;
      assign rd_busy[p] = b_q;
   end

endmodule
